// File: rtl/led_frame_fetch.sv
// LED panel frame fetcher. For each (row pair, bit-plane) it reads the top and
// bottom pixel of every column from frame RAM, slices the current bit-plane
// out of each colour channel and presents the packed row to the panel driver
// over a valid/ready handshake. Frames are double-buffered; a requested
// buffer swap takes effect only at a frame boundary.
module led_frame_fetch #(
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = 64,
    parameter int BPC            = 4,
    parameter int RAM_LATENCY    = 1,
    parameter int ADDR_W         = 32,
    localparam int ROW_W   = (NUM_ROW_PIXELS / 2 > 1) ? $clog2(NUM_ROW_PIXELS / 2) : 1,
    localparam int PLANE_W = (BPC > 1) ? $clog2(BPC) : 1
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic                          enable_in,
    input  logic                          swap_req_in,
    output logic                          swap_ack_out,
    output logic                          active_buf_out,
    output logic                          ram_rd_en_out,
    output logic [ADDR_W-1:0]             ram_address_out,
    input  logic [31:0]                   ram_rdata_in,
    output logic [6*NUM_COL_PIXELS-1:0]   row_out,
    output logic                          row_valid_out,
    input  logic                          row_ready_in,
    output logic [ROW_W-1:0]              row_address_out,
    output logic [PLANE_W-1:0]            plane_out
);

    localparam int HALF_ROWS = NUM_ROW_PIXELS / 2;
    localparam int FRAME     = NUM_ROW_PIXELS * NUM_COL_PIXELS;
    localparam int READS     = 2 * NUM_COL_PIXELS;
    localparam int CNT_W     = $clog2(READS);
    localparam int IDX_W     = $clog2(6 * NUM_COL_PIXELS);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PRESENT} state_t;

    state_t                       state, state_next;
    logic [CNT_W-1:0]             cnt;
    logic [ROW_W-1:0]             row_cnt;
    logic [PLANE_W-1:0]           plane_cnt;
    logic                         active_buf, swap_pending, swap_ack;
    logic [6*NUM_COL_PIXELS-1:0]  row_q;
    logic [RAM_LATENCY-1:0]       pipe_vld;
    logic [CNT_W-1:0]             pipe_idx [RAM_LATENCY];
    logic                         xfer, last_row, last_plane, frame_end;
    logic [ADDR_W-1:0]            pix_row;
    logic [CNT_W-1:0]             cap_idx;
    logic [IDX_W-1:0]             cap_base;
    logic [4:0]                   r_idx, g_idx, b_idx;
    logic [2:0]                   cap_bits;

    assign xfer       = (state == PRESENT) && row_ready_in;
    assign last_plane = (plane_cnt == PLANE_W'(BPC - 1));
    assign last_row   = (row_cnt == ROW_W'(HALF_ROWS - 1));
    assign frame_end  = xfer && last_row && last_plane;

    // State register
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its inputs from the same edge, independent of block order.
        if (reset_in) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode: fetch a row, wait out RAM latency, hold until accepted
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (enable_in) state_next = FETCH;
            FETCH:   if (cnt == CNT_W'(READS - 1)) state_next = DRAIN;
            DRAIN:   if (cnt == CNT_W'(RAM_LATENCY - 1)) state_next = PRESENT;
            PRESENT: if (xfer) state_next = frame_end ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Per-state cycle counter: read index in FETCH, latency count in DRAIN
    always_ff @(posedge clk_in) begin
        if (reset_in)                                cnt <= '0;
        else if (state_next != state)                cnt <= '0;
        else if (state == FETCH || state == DRAIN)   cnt <= cnt + CNT_W'(1);
    end

    // Read strobe and address: even reads fetch the top pixel, odd the bottom
    always_comb begin
        ram_rd_en_out   = (state == FETCH);
        pix_row         = ADDR_W'(row_cnt) + (cnt[0] ? ADDR_W'(HALF_ROWS) : '0);
        ram_address_out = '0;
        if (state == FETCH)
            ram_address_out = (active_buf ? ADDR_W'(FRAME) : '0)
                            + pix_row * ADDR_W'(NUM_COL_PIXELS)
                            + ADDR_W'(cnt[CNT_W-1:1]);
    end

    // Valid tags travelling alongside outstanding RAM reads
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= ram_rd_en_out;
            for (int i = 1; i < RAM_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    // Read-index tags for outstanding RAM reads
    always_ff @(posedge clk_in) begin
        // NOTE: the index tags carry no reset; they are only consumed when the
        // matching valid tag (which is reset) is set.
        pipe_idx[0] <= cnt;
        for (int i = 1; i < RAM_LATENCY; i++) pipe_idx[i] <= pipe_idx[i-1];
    end

    // Locate the returning pixel in the row and slice out the current plane
    always_comb begin
        cap_idx  = pipe_idx[RAM_LATENCY-1];
        cap_base = IDX_W'(cap_idx[CNT_W-1:1]) * IDX_W'(6)
                 + (cap_idx[0] ? IDX_W'(3) : IDX_W'(0));
        r_idx    = 5'(plane_cnt);
        g_idx    = 5'(BPC) + r_idx;
        b_idx    = 5'(2 * BPC) + r_idx;
        cap_bits = {ram_rdata_in[b_idx], ram_rdata_in[g_idx], ram_rdata_in[r_idx]};
    end

    // Row assembly register; held untouched while the row is presented
    always_ff @(posedge clk_in) begin
        if (reset_in)                       row_q <= '0;
        else if (pipe_vld[RAM_LATENCY-1])   row_q[cap_base +: 3] <= cap_bits;
    end

    // Plane/row sequencing and frame-boundary buffer swap
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            row_cnt      <= '0;
            plane_cnt    <= '0;
            active_buf   <= 1'b0;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            if (xfer) begin
                if (last_plane) begin
                    plane_cnt <= '0;
                    row_cnt   <= last_row ? '0 : row_cnt + ROW_W'(1);
                end else begin
                    plane_cnt <= plane_cnt + PLANE_W'(1);
                end
            end
            if (frame_end) begin
                if (swap_pending || swap_req_in) begin
                    active_buf <= ~active_buf;
                    swap_ack   <= 1'b1;
                end
                swap_pending <= 1'b0;
            end else if (swap_req_in) begin
                swap_pending <= 1'b1;
            end
        end
    end

    assign row_out         = row_q;
    assign row_valid_out   = (state == PRESENT);
    assign row_address_out = row_cnt;
    assign plane_out       = plane_cnt;
    assign active_buf_out  = active_buf;
    assign swap_ack_out    = swap_ack;

endmodule

// File: doc/led_frame_fetch.md
LED_FRAME_FETCH -- requirements
Module: led_frame_fetch

Interface
REQ-001 SHALL have parameter NUM_ROW_PIXELS, default 32, meaning panel rows; even, >=4.
REQ-002 SHALL have parameter NUM_COL_PIXELS, default 64, meaning panel columns; >=2.
REQ-003 SHALL have parameter BPC, default 4, meaning bits per colour channel (1..8); one bit-plane per bit.
REQ-004 SHALL have parameter RAM_LATENCY, default 1, meaning read latency in cycles (1 or 2).
REQ-005 SHALL have parameter ADDR_W, default 32, meaning RAM word-address width.
REQ-006 SHALL have port clk_in, input, 1, meaning single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset_in, input, 1, meaning reset, synchronous and active-high.
REQ-008 SHALL have port enable_in, input, 1, meaning scan enable; sampled only in IDLE.
REQ-009 SHALL have port swap_req_in, input, 1, meaning one-cycle pulse requesting a display-buffer swap.
REQ-010 SHALL have port swap_ack_out, output, 1, meaning one-cycle pulse when the swap takes effect.
REQ-011 SHALL have port active_buf_out, output, 1, meaning index of the buffer being displayed.
REQ-012 SHALL have port ram_rd_en_out, output, 1, meaning read strobe.
REQ-013 SHALL have port ram_address_out, output, ADDR_W, meaning word address.
REQ-014 SHALL have port ram_rdata_in, input, 32, meaning read data; pixel packed as R[BPC-1:0], G[2BPC-1:BPC], B[3BPC-1:2BPC].
REQ-015 SHALL have port row_out, output, 6*NUM_COL_PIXELS, meaning column c at [6c+5:6c] = {b_bot,g_bot,r_bot,b_top,g_top,r_top}.
REQ-016 SHALL have port row_valid_out, output, 1, meaning row_out is valid.
REQ-017 SHALL have port row_ready_in, input, 1, meaning downstream accepts the row.
REQ-018 SHALL have port row_address_out, output, clog2(NUM_ROW_PIXELS/2), meaning row-pair index.
REQ-019 SHALL have port plane_out, output, clog2(BPC) (min 1), meaning bit-plane index of row_out.

Function
REQ-020 SHALL implement an FSM with states IDLE, FETCH, DRAIN, PRESENT.
REQ-021 In IDLE, SHALL enter FETCH on the next cycle when enable_in=1.
REQ-022 In FETCH, SHALL assert ram_rd_en_out for 2*NUM_COL_PIXELS consecutive cycles: top pixel then bottom pixel per column, columns 0..NUM_COL_PIXELS-1.
REQ-023 Top address SHALL be buf*FRAME + a*NUM_COL_PIXELS + c; bottom address SHALL be buf*FRAME + (a+NUM_ROW_PIXELS/2)*NUM_COL_PIXELS + c; FRAME = NUM_ROW_PIXELS*NUM_COL_PIXELS; all truncated to ADDR_W.
REQ-024 Data for a read issued in cycle t SHALL be captured at t+RAM_LATENCY; the block SHALL extract bit plane_out of each channel.
REQ-025 DRAIN SHALL last RAM_LATENCY cycles, then enter PRESENT.
REQ-026 PRESENT SHALL hold row_valid_out=1 with row_out, row_address_out and plane_out stable until row_ready_in=1; transfer occurs on valid&ready.
REQ-027 Sequence order SHALL be: plane inner (0..BPC-1), row pair outer (0..NUM_ROW_PIXELS/2-1); each (row, plane) SHALL re-fetch from RAM.
REQ-028 After each transfer that is not at a frame end, SHALL return to FETCH the next cycle.
REQ-029 After a transfer of the last row pair and last plane (frame end), SHALL go to IDLE.
REQ-030 A swap_req_in pulse SHALL set a pending flag; the pending flag SHALL be ignored if already set.
REQ-031 At frame end with the flag pending, SHALL toggle active_buf_out, pulse swap_ack_out in the same cycle as the IDLE entry, and clear the flag.
REQ-032 If swap_req_in and the frame-end transfer coincide, the request SHALL be honoured in that same frame end.
REQ-033 The buffer SHALL never change mid-frame.
REQ-034 enable_in deassertion mid-frame SHALL NOT abort; the frame SHALL complete, then the block stays in IDLE.
REQ-035 ram_rd_en_out SHALL be 0 outside FETCH; ram_address_out is don't-care when the strobe is low.

Reset
REQ-036 While reset_in=1 at a clock edge: state=IDLE, row_valid_out=0, ram_rd_en_out=0, swap_ack_out=0, active_buf_out=0, pending=0, row/plane counters=0, row_out=0, ram_address_out=0.
REQ-037 Reset asserted mid-FETCH or mid-PRESENT SHALL take effect on the next edge; any held row SHALL be discarded.

Verification
REQ-038 Defaults, RAM word k = k, ready tied 1, enable=1 -> first row_valid_out after 128+1+1 cycles; row_address_out=0, plane_out=0; row_out matches bit0 of addresses 0..63 / 1024..1087.
REQ-039 ready held 0 for 50 cycles during PRESENT -> row_valid_out and row_out stable throughout; no RAM reads issued.
REQ-040 Full frame with ready=1 -> exactly 64 transfers in order (row 0 planes 0..3, then row 1 ...), then IDLE.
REQ-041 swap_req_in pulsed mid-frame -> active_buf_out flips only at frame end with one swap_ack_out pulse; the next frame's addresses start at 2048.
REQ-042 Reset pulsed during FETCH of row 5 -> next frame restarts at row 0, plane 0, buffer 0.
REQ-043 RAM_LATENCY=2, BPC=8, NUM_ROW_PIXELS=16, NUM_COL_PIXELS=32 -> correct plane 7 bits; DRAIN of 2 cycles.
